// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a shared single-port memory.
// Fixed-priority or round-robin grant, one access every three cycles.
module mem_arbiter #(
  parameter int unsigned FAIR = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_wmask,
  input  logic        p0_rstrb,
  output logic [31:0] p0_rdata,
  output logic        p0_ready,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_wmask,
  input  logic        p1_rstrb,
  output logic [31:0] p1_rdata,
  output logic        p1_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t        state;
  logic          grant;
  logic          last_grant;
  logic          is_read;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;

  logic          req0;
  logic          req1;
  logic          win;

  // Request decode and winner selection
  always_comb begin
    req0 = p0_rstrb | (p0_wmask != '0);
    req1 = p1_rstrb | (p1_wmask != '0);
    win  = 1'b0;
    if (req0 && req1) begin
      win = (FAIR != 0) ? ~last_grant : 1'b0;
    end else begin
      win = req1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      is_read    <= 1'b0;
      busy       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      mem_rstrb  <= 1'b0;
      p0_ready   <= 1'b0;
      p1_ready   <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state      <= ISSUE;
            busy       <= 1'b1;
            grant      <= win;
            last_grant <= win;
            mem_addr   <= win ? p1_addr  : p0_addr;
            mem_wdata  <= win ? p1_wdata : p0_wdata;
            mem_wmask  <= win ? p1_wmask : p0_wmask;
            // A nonzero mask makes the access a write, whatever rstrb says
            mem_rstrb  <= win ? (p1_wmask == MW'(0)) : (p0_wmask == MW'(0));
            is_read    <= win ? (p1_wmask == MW'(0)) : (p0_wmask == MW'(0));
          end
        end
        ISSUE: begin
          state     <= RESP;
          mem_wmask <= '0;
          mem_rstrb <= 1'b0;
          p0_ready  <= ~grant;
          p1_ready  <= grant;
        end
        RESP: begin
          state    <= IDLE;
          busy     <= 1'b0;
          p0_ready <= 1'b0;
          p1_ready <= 1'b0;
          if (is_read) begin
            if (grant) rdata1_q <= mem_rdata;
            else       rdata0_q <= mem_rdata;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          mem_wmask <= '0;
          mem_rstrb <= 1'b0;
          p0_ready  <= 1'b0;
          p1_ready  <= 1'b0;
        end
      endcase
    end
  end

  // Read data is passed straight through during RESP, then held
  assign p0_rdata = (state == RESP && !grant && is_read) ? mem_rdata : rdata0_q;
  assign p1_rdata = (state == RESP &&  grant && is_read) ? mem_rdata : rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: FAIR=1 (inst0) and FAIR=0 (inst1) side by side,
// each with its own memory, checked every cycle against a transaction model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] p_addr  [2][2];
  logic [31:0] p_wdata [2][2];
  logic [3:0]  p_wmask [2][2];
  logic        p_rstrb [2][2];
  logic [31:0] p_rdata [2][2];
  logic        p_ready [2][2];
  logic [31:0] mem_addr_o  [2];
  logic [31:0] mem_wdata_o [2];
  logic [3:0]  mem_wmask_o [2];
  logic        mem_rstrb_o [2];
  logic        busy_o      [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 100) return 32'h04030201;
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic [31:0] mrd;
    logic [31:0] mem [1024];

    // Memory: registered read, byte-masked write; reloaded while reset is high
    always @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      end else begin
        if (mem_rstrb_o[k]) mrd <= mem[mem_addr_o[k][11:2]];
        for (int b = 0; b < 4; b++)
          if (mem_wmask_o[k][b]) mem[mem_addr_o[k][11:2]][8*b +: 8] <= mem_wdata_o[k][8*b +: 8];
      end
    end

    mem_arbiter #(.FAIR(k == 0 ? 1 : 0)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .p0_addr   (p_addr[k][0]),
      .p0_wdata  (p_wdata[k][0]),
      .p0_wmask  (p_wmask[k][0]),
      .p0_rstrb  (p_rstrb[k][0]),
      .p0_rdata  (p_rdata[k][0]),
      .p0_ready  (p_ready[k][0]),
      .p1_addr   (p_addr[k][1]),
      .p1_wdata  (p_wdata[k][1]),
      .p1_wmask  (p_wmask[k][1]),
      .p1_rstrb  (p_rstrb[k][1]),
      .p1_rdata  (p_rdata[k][1]),
      .p1_ready  (p_ready[k][1]),
      .mem_addr  (mem_addr_o[k]),
      .mem_wdata (mem_wdata_o[k]),
      .mem_wmask (mem_wmask_o[k]),
      .mem_rstrb (mem_rstrb_o[k]),
      .mem_rdata (mrd),
      .busy      (busy_o[k])
    );
  end

  // Transaction-level model: one outstanding access per instance
  bit          act     [2];
  int          free_at [2];
  int          t_start [2];
  int          t_port  [2];
  bit          t_read  [2];
  logic [31:0] t_addr  [2];
  logic [31:0] t_wdata [2];
  logic [3:0]  t_wmask [2];
  logic [31:0] t_rval  [2];
  int          last_g  [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] exp_rd  [2][2];
  logic [31:0] ref_mem [2][1024];

  task automatic check(input string name, input int k, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d: got %h expected %h", name, k, cyc, act_v, exp_v);
    end
  endtask

  task automatic model_step();
    bit r0, r1;
    int w, idx;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        act[k]     = 1'b0;
        free_at[k] = cyc + 1;
        last_g[k]  = 1;
        m_addr[k]  = '0;
        m_wdata[k] = '0;
        exp_rd[k][0] = '0;
        exp_rd[k][1] = '0;
        for (int i = 0; i < 1024; i++) ref_mem[k][i] = init_word(i);
      end else begin
        if (act[k] && cyc == t_start[k] + 2) begin
          if (t_read[k]) exp_rd[k][t_port[k]] = t_rval[k];
          act[k] = 1'b0;
        end
        if (cyc >= free_at[k]) begin
          r0 = p_rstrb[k][0] || (p_wmask[k][0] != 4'h0);
          r1 = p_rstrb[k][1] || (p_wmask[k][1] != 4'h0);
          if (r0 || r1) begin
            if (r0 && r1) w = (k == 0) ? 1 - last_g[k] : 0;
            else          w = r1 ? 1 : 0;
            act[k]     = 1'b1;
            t_start[k] = cyc;
            free_at[k] = cyc + 3;
            t_port[k]  = w;
            last_g[k]  = w;
            t_addr[k]  = p_addr[k][w];
            t_wdata[k] = p_wdata[k][w];
            t_wmask[k] = p_wmask[k][w];
            t_read[k]  = (p_wmask[k][w] == 4'h0);
            m_addr[k]  = t_addr[k];
            m_wdata[k] = t_wdata[k];
            idx = int'(t_addr[k][11:2]);
            if (t_read[k]) t_rval[k] = ref_mem[k][idx];
            else
              for (int b = 0; b < 4; b++)
                if (t_wmask[k][b]) ref_mem[k][idx][8*b +: 8] = t_wdata[k][8*b +: 8];
          end
        end
      end
    end
    cyc++;
  endtask

  task automatic compare_all();
    bit issue, resp;
    logic [31:0] er;
    for (int k = 0; k < 2; k++) begin
      issue = act[k] && (cyc == t_start[k] + 1);
      resp  = act[k] && (cyc == t_start[k] + 2);
      check("busy",      k, 32'(busy_o[k]),      32'(issue || resp));
      check("mem_wmask", k, 32'(mem_wmask_o[k]), issue ? 32'(t_wmask[k]) : 32'd0);
      check("mem_rstrb", k, 32'(mem_rstrb_o[k]), 32'(issue && t_read[k]));
      check("mem_addr",  k, mem_addr_o[k],       m_addr[k]);
      check("mem_wdata", k, mem_wdata_o[k],      m_wdata[k]);
      for (int p = 0; p < 2; p++) begin
        check(p == 0 ? "p0_ready" : "p1_ready", k, 32'(p_ready[k][p]), 32'(resp && t_port[k] == p));
        er = (resp && t_port[k] == p && t_read[k]) ? t_rval[k] : exp_rd[k][p];
        check(p == 0 ? "p0_rdata" : "p1_rdata", k, p_rdata[k][p], er);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) compare_all();
  end

  task automatic set_req(input int k, input int p, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] wm, input logic rs);
    p_addr[k][p]  = a;
    p_wdata[k][p] = wd;
    p_wmask[k][p] = wm;
    p_rstrb[k][p] = rs;
  endtask

  task automatic clr_req(input int k, input int p);
    p_wmask[k][p] = 4'h0;
    p_rstrb[k][p] = 1'b0;
  endtask

  // Single-requester access on both instances, entered and left at the negedge of an IDLE cycle
  task automatic single_txn(input int p, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] wm, input logic rs, output logic [31:0] rd);
    for (int k = 0; k < 2; k++) set_req(k, p, a, wd, wm, rs);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("issue_addr",  k, mem_addr_o[k], a);
      check("issue_wmask", k, 32'(mem_wmask_o[k]), 32'(wm));
      check("issue_rstrb", k, 32'(mem_rstrb_o[k]), 32'(rs && wm == 4'h0));
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("resp_ready",  k, 32'(p_ready[k][p]), 32'd1);
      check("other_ready", k, 32'(p_ready[k][1-p]), 32'd0);
      clr_req(k, p);
    end
    rd = p_rdata[0][p];
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("idle_busy",  k, 32'(busy_o[k]), 32'd0);
      check("idle_wmask", k, 32'(mem_wmask_o[k]), 32'd0);
    end
  endtask

  task automatic drive(input int k, input int p);
    for (int n = 0; n < 20; n++) begin
      int w;
      int op;
      logic [3:0] wm;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      op = int'($urandom_range(0, 2));
      wm = (op == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      set_req(k, p, 32'((100 + $urandom_range(0, 7)) * 4), $urandom, wm, op != 1);
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!p_ready[k][p] && w < 100);
      check(p == 0 ? "p0_completes" : "p1_completes", k, 32'(p_ready[k][p]), 32'd1);
      clr_req(k, p);
    end
  endtask

  int gcnt [2];
  int gseq [2][4];
  int gcyc [2][4];
  logic [31:0] rd;

  initial begin
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) begin
        set_req(k, p, 32'h0, 32'h0, 4'h0, 1'b0);
        gcnt[k] = 0;
      end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;

    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_busy",     k, 32'(busy_o[k]), 32'd0);
      check("rst_mem_addr", k, mem_addr_o[k], 32'h0);
      check("rst_p0_rdata", k, p_rdata[k][0], 32'h0);
      check("rst_p1_rdata", k, p_rdata[k][1], 32'h0);
      check("rst_ready",    k, 32'(p_ready[k][0] | p_ready[k][1]), 32'd0);
    end

    single_txn(0, 32'd400, 32'h0, 4'h0, 1'b1, rd);
    check("read_400", 0, rd, 32'h04030201);

    single_txn(1, 32'd800, 32'h0000AB00, 4'b0010, 1'b0, rd);
    single_txn(1, 32'd800, 32'h0, 4'h0, 1'b1, rd);
    check("read_800_byte1", 0, 32'(rd[15:8]), 32'hAB);

    single_txn(0, 32'd404, 32'hDEADBEEF, 4'hF, 1'b1, rd);
    single_txn(0, 32'd404, 32'h0, 4'h0, 1'b1, rd);
    check("read_404", 0, rd, 32'hDEADBEEF);

    // Abort a write during ISSUE
    for (int k = 0; k < 2; k++) set_req(k, 1, 32'd808, 32'h12345678, 4'hF, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) check("abort_issue_wmask", k, 32'(mem_wmask_o[k]), 32'hF);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) clr_req(k, 1);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("abort_busy",  k, 32'(busy_o[k]), 32'd0);
      check("abort_wmask", k, 32'(mem_wmask_o[k]), 32'd0);
      check("abort_ready", k, 32'(p_ready[k][0] | p_ready[k][1]), 32'd0);
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) check("abort_no_late_ready", k, 32'(p_ready[k][1]), 32'd0);

    // Both ports reading continuously
    for (int k = 0; k < 2; k++) begin
      set_req(k, 0, 32'd400, 32'h0, 4'h0, 1'b1);
      set_req(k, 1, 32'd800, 32'h0, 4'h0, 1'b1);
    end
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        for (int p = 0; p < 2; p++)
          if (p_ready[k][p]) begin
            if (gcnt[k] < 4) begin
              gseq[k][gcnt[k]] = p;
              gcyc[k][gcnt[k]] = i;
            end
            gcnt[k]++;
          end
      if (i == 11) for (int k = 0; k < 2; k++) clr_req(k, 0);
    end
    for (int k = 0; k < 2; k++) begin
      check("grant_count", k, 32'(gcnt[k]), 32'd4);
      for (int j = 0; j < 4; j++) begin
        check("grant_port",  k, 32'(gseq[k][j]), (k == 0) ? 32'(j % 2) : 32'd0);
        check("grant_cycle", k, 32'(gcyc[k][j]), 32'(2 + 3 * j));
      end
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("p1_after_drop", k, 32'(p_ready[k][1]), 32'd1);
      clr_req(k, 1);
    end
    @(negedge clk);

    fork
      drive(0, 0);
      drive(0, 1);
      drive(1, 0);
      drive(1, 1);
    join
    repeat (5) @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
